// File: rtl/rom_arb_pkg.sv
// Shared types and the address range check for the dual-bank ROM arbiter.
package rom_arb_pkg;

  typedef enum logic {
    PORT_IFU = 1'b0,
    PORT_DAT = 1'b1
  } port_e;

  typedef struct packed {
    port_e port;
    logic  odd;
    logic  wide;
    logic  err;
  } rsp_tag_t;

  // Offsets wrap at 16 bits, so addresses just below the base land far out of range.
  function automatic logic inRange(input logic [15:0] addr, input logic wide,
                                   input logic [15:0] base, input logic [16:0] size);
    logic [15:0] offset;
    logic [15:0] offsetNext;
    offset     = addr - base;
    offsetNext = offset + 16'd1;
    return ({1'b0, offset} < size) && (!wide || ({1'b0, offsetNext} < size));
  endfunction

endpackage

// File: rtl/rom_arb_steer.sv
// Byte-lane steering of the two ROM bank bytes into a little-endian response word.
module rom_arb_steer
  import rom_arb_pkg::*;
(
  input  rsp_tag_t    tag_i,
  input  logic [7:0]  evenByte_i,
  input  logic [7:0]  oddByte_i,
  output logic [15:0] data_o
);

  // An odd start address swaps the lanes; the high byte only exists for wide reads.
  always_comb begin
    data_o = 16'h0000;
    if (!tag_i.err) begin
      data_o[7:0] = tag_i.odd ? oddByte_i : evenByte_i;
      if (tag_i.wide) begin
        data_o[15:8] = tag_i.odd ? evenByte_i : oddByte_i;
      end
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Arbitrates the ifu and data ports onto a dual-bank (even/odd byte) synchronous ROM.
// Define ROM_ARB_FAIR_EN for round-robin tie breaking; otherwise dat has fixed priority.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned SIZE    = 2048,
  parameter logic [15:0] ROMBASE = 16'h4000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ifu_req,
  input  logic [15:0] ifu_addr,
  input  logic        ifu_wide,
  output logic        ifu_gnt,
  output logic        ifu_rvalid,
  output logic [15:0] ifu_rdata,
  output logic        ifu_rerr,
  input  logic        dat_req,
  input  logic [15:0] dat_addr,
  input  logic        dat_wide,
  output logic        dat_gnt,
  output logic        dat_rvalid,
  output logic [15:0] dat_rdata,
  output logic        dat_rerr,
  output logic [14:0] rom_addr_even,
  output logic [14:0] rom_addr_odd,
  input  logic [7:0]  rom_data_even,
  input  logic [7:0]  rom_data_odd
);

  logic        ifuGnt;
  logic        datGnt;
  logic        anyGnt;
  port_e       selPort;
  logic [15:0] selAddr;
  logic [15:0] addrInc;
  logic        selWide;
  logic [14:0] evenAddr_d, evenAddr_q;
  logic [14:0] oddAddr_d, oddAddr_q;
  logic        valid_d, valid_q;
  rsp_tag_t    tag_d, tag_q;
  logic [15:0] steerData;

`ifdef ROM_ARB_FAIR_EN
  port_e lastGnt_d, lastGnt_q;
`endif

  // Grants are suppressed during reset so nothing is issued into a clearing pipeline.
  always_comb begin
    ifuGnt = 1'b0;
    datGnt = 1'b0;
    if (!reset) begin
      if (ifu_req && dat_req) begin
`ifdef ROM_ARB_FAIR_EN
        if (lastGnt_q == PORT_DAT) begin
          ifuGnt = 1'b1;
        end else begin
          datGnt = 1'b1;
        end
`else
        datGnt = 1'b1;
`endif
      end else if (ifu_req) begin
        ifuGnt = 1'b1;
      end else if (dat_req) begin
        datGnt = 1'b1;
      end
    end
  end

  // An odd address needs the even byte of the next word, hence the 16-bit increment.
  always_comb begin
    anyGnt    = ifuGnt || datGnt;
    selPort   = datGnt ? PORT_DAT : PORT_IFU;
    selAddr   = datGnt ? dat_addr : ifu_addr;
    selWide   = datGnt ? dat_wide : ifu_wide;
    addrInc   = selAddr + 16'd1;
    oddAddr_d = anyGnt ? selAddr[15:1] : oddAddr_q;
    evenAddr_d = evenAddr_q;
    if (anyGnt) begin
      evenAddr_d = selAddr[0] ? addrInc[15:1] : selAddr[15:1];
    end
    valid_d = anyGnt;
    tag_d   = '{port: selPort, odd: selAddr[0], wide: selWide,
                err: !inRange(selAddr, selWide, ROMBASE, 17'(SIZE))};
  end

`ifdef ROM_ARB_FAIR_EN
  assign lastGnt_d = anyGnt ? selPort : lastGnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lastGnt_q <= PORT_DAT;
    end else begin
      lastGnt_q <= lastGnt_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evenAddr_q <= 15'h0000;
      oddAddr_q  <= 15'h0000;
      valid_q    <= 1'b0;
      tag_q      <= '{port: PORT_IFU, odd: 1'b0, wide: 1'b0, err: 1'b0};
    end else begin
      evenAddr_q <= evenAddr_d;
      oddAddr_q  <= oddAddr_d;
      valid_q    <= valid_d;
      tag_q      <= tag_d;
    end
  end

  rom_arb_steer u_steer (
    .tag_i      (tag_q),
    .evenByte_i (rom_data_even),
    .oddByte_i  (rom_data_odd),
    .data_o     (steerData)
  );

  assign ifu_gnt       = ifuGnt;
  assign dat_gnt       = datGnt;
  assign rom_addr_even = evenAddr_d;
  assign rom_addr_odd  = oddAddr_d;

  assign ifu_rvalid = valid_q && (tag_q.port == PORT_IFU);
  assign dat_rvalid = valid_q && (tag_q.port == PORT_DAT);
  assign ifu_rdata  = ifu_rvalid ? steerData : 16'h0000;
  assign dat_rdata  = dat_rvalid ? steerData : 16'h0000;
  assign ifu_rerr   = ifu_rvalid && tag_q.err;
  assign dat_rerr   = dat_rvalid && tag_q.err;

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: directed and random reads against a ROM whose byte at address A is A[7:0].
// Honours ROM_ARB_FAIR_EN for the expected tie-breaking behaviour.
module tb_rom_arbiter;

  localparam logic [15:0] BASE      = 16'h4000;
  localparam logic [15:0] WRAP_BASE = 16'hF800;
  localparam int          ROM_SIZE  = 2048;

  logic        clk;
  logic        reset;
  logic        ifuReq, ifuWide, ifuGnt, ifuRvalid, ifuRerr;
  logic [15:0] ifuAddr, ifuRdata;
  logic        datReq, datWide, datGnt, datRvalid, datRerr;
  logic [15:0] datAddr, datRdata;
  logic [14:0] romAddrEven, romAddrOdd;
  logic [7:0]  romDataEven, romDataOdd;

  logic        wIfuReq, wIfuWide, wIfuGnt, wIfuRvalid, wIfuRerr;
  logic [15:0] wIfuAddr, wIfuRdata;
  logic        wDatReq, wDatWide, wDatGnt, wDatRvalid, wDatRerr;
  logic [15:0] wDatAddr, wDatRdata;
  logic [14:0] wRomAddrEven, wRomAddrOdd;
  logic [7:0]  wRomDataEven, wRomDataOdd;

  int testsRun    = 0;
  int testsFailed = 0;

`ifdef ROM_ARB_FAIR_EN
  bit lastWinner = 1'b1;
`endif

  rom_arbiter #(.SIZE(ROM_SIZE), .ROMBASE(BASE)) dut (
    .clk(clk), .reset(reset),
    .ifu_req(ifuReq), .ifu_addr(ifuAddr), .ifu_wide(ifuWide), .ifu_gnt(ifuGnt),
    .ifu_rvalid(ifuRvalid), .ifu_rdata(ifuRdata), .ifu_rerr(ifuRerr),
    .dat_req(datReq), .dat_addr(datAddr), .dat_wide(datWide), .dat_gnt(datGnt),
    .dat_rvalid(datRvalid), .dat_rdata(datRdata), .dat_rerr(datRerr),
    .rom_addr_even(romAddrEven), .rom_addr_odd(romAddrOdd),
    .rom_data_even(romDataEven), .rom_data_odd(romDataOdd)
  );

  rom_arbiter #(.SIZE(ROM_SIZE), .ROMBASE(WRAP_BASE)) dutWrap (
    .clk(clk), .reset(reset),
    .ifu_req(wIfuReq), .ifu_addr(wIfuAddr), .ifu_wide(wIfuWide), .ifu_gnt(wIfuGnt),
    .ifu_rvalid(wIfuRvalid), .ifu_rdata(wIfuRdata), .ifu_rerr(wIfuRerr),
    .dat_req(wDatReq), .dat_addr(wDatAddr), .dat_wide(wDatWide), .dat_gnt(wDatGnt),
    .dat_rvalid(wDatRvalid), .dat_rdata(wDatRdata), .dat_rerr(wDatRerr),
    .rom_addr_even(wRomAddrEven), .rom_addr_odd(wRomAddrOdd),
    .rom_data_even(wRomDataEven), .rom_data_odd(wRomDataOdd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Both bases are 256-aligned, so "byte at offset i = i[7:0]" is simply the address low byte.
  always @(posedge clk) begin
    romDataEven  <= {romAddrEven[6:0], 1'b0};
    romDataOdd   <= {romAddrOdd[6:0], 1'b1};
    wRomDataEven <= {wRomAddrEven[6:0], 1'b0};
    wRomDataOdd  <= {wRomAddrOdd[6:0], 1'b1};
  end

  function automatic logic refErr(input logic [15:0] a, input logic wide, input logic [15:0] base);
    int o;
    o = (int'(a) - int'(base)) & 32'h0000FFFF;
    if (o >= ROM_SIZE) return 1'b1;
    if (wide && (((o + 1) & 32'h0000FFFF) >= ROM_SIZE)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [15:0] refData(input logic [15:0] a, input logic wide, input logic [15:0] base);
    logic [15:0] nextA;
    nextA = a + 16'd1;
    if (refErr(a, wide, base)) return 16'h0000;
    return {wide ? nextA[7:0] : 8'h00, a[7:0]};
  endfunction

  function automatic logic [14:0] refEven(input logic [15:0] a);
    logic [15:0] e;
    e = a[0] ? a + 16'd1 : a;
    return e[15:1];
  endfunction

  function automatic logic [14:0] refOdd(input logic [15:0] a);
    return a[15:1];
  endfunction

  function automatic logic [15:0] randAddr();
    case ($urandom_range(0, 3))
      0:       return BASE + 16'($urandom_range(0, ROM_SIZE - 1));
      1:       return 16'h47F8 + 16'($urandom_range(0, 15));
      2:       return 16'h3FF8 + 16'($urandom_range(0, 15));
      default: return 16'($urandom);
    endcase
  endfunction

  // 0 = ifu, 1 = dat
  function automatic bit tieWinner();
`ifdef ROM_ARB_FAIR_EN
    return !lastWinner;
`else
    return 1'b1;
`endif
  endfunction

  task automatic noteGrant(input bit win);
`ifdef ROM_ARB_FAIR_EN
    lastWinner = win;
`else
    if (win !== 1'b1 && win !== 1'b0) $display("[TB] unexpected winner value");
`endif
  endtask

  task automatic pulseReset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
`ifdef ROM_ARB_FAIR_EN
    lastWinner = 1'b1;
`endif
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    ifuReq  = 1'b1; ifuAddr = 16'h4010; ifuWide = 1'b1;
    datReq  = 1'b1; datAddr = 16'h4011; datWide = 1'b1;
    wIfuReq = 1'b0; wIfuAddr = 16'h0000; wIfuWide = 1'b0;
    wDatReq = 1'b0; wDatAddr = 16'h0000; wDatWide = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    testsRun++;
    if ({ifuGnt, datGnt} !== 2'b00) begin
      testsFailed++;
      $display("[TB] FAIL reset_gnt: got %b expected 00", {ifuGnt, datGnt});
    end
    testsRun++;
    if ({ifuRvalid, datRvalid, ifuRerr, datRerr, ifuRdata, datRdata} !== 36'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_rsp: got %h expected 0",
               {ifuRvalid, datRvalid, ifuRerr, datRerr, ifuRdata, datRdata});
    end
    testsRun++;
    if ({romAddrEven, romAddrOdd} !== 30'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_addr: got %h/%h expected 0/0", romAddrEven, romAddrOdd);
    end
    ifuReq = 1'b0; datReq = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_single();
    bit          tPort[$];
    logic [15:0] tAddr[$];
    bit          tWide[$];
    tPort = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tAddr = '{16'h4010, 16'h4011, 16'h47FF, 16'h47FF, 16'h3FFF, 16'h4000};
    tWide = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 16; i++) begin
      tPort.push_back(1'($urandom_range(0, 1)));
      tAddr.push_back(randAddr());
      tWide.push_back(1'($urandom_range(0, 1)));
    end
    foreach (tAddr[i]) begin
      logic [15:0] a;
      logic [15:0] expData;
      logic        expErr;
      logic [1:0]  expPair;
      a       = tAddr[i];
      expPair = tPort[i] ? 2'b01 : 2'b10;
      expData = refData(a, tWide[i], BASE);
      expErr  = refErr(a, tWide[i], BASE);
      @(posedge clk); #1;
      ifuReq = !tPort[i]; datReq = tPort[i];
      ifuAddr = a; datAddr = a; ifuWide = tWide[i]; datWide = tWide[i];
      @(negedge clk);
      testsRun++;
      if ({ifuGnt, datGnt} !== expPair) begin
        testsFailed++;
        $display("[TB] FAIL single_gnt[%0d]: got %b expected %b", i, {ifuGnt, datGnt}, expPair);
      end
      testsRun++;
      if ({romAddrEven, romAddrOdd} !== {refEven(a), refOdd(a)}) begin
        testsFailed++;
        $display("[TB] FAIL single_addr[%0d] a=%h: got %h/%h expected %h/%h", i, a,
                 romAddrEven, romAddrOdd, refEven(a), refOdd(a));
      end
      @(posedge clk); #1;
      ifuReq = 1'b0; datReq = 1'b0;
      @(negedge clk);
      testsRun++;
      if ({ifuRvalid, datRvalid} !== expPair) begin
        testsFailed++;
        $display("[TB] FAIL single_rvalid[%0d]: got %b expected %b", i, {ifuRvalid, datRvalid}, expPair);
      end
      testsRun++;
      if ((tPort[i] ? {datRerr, datRdata} : {ifuRerr, ifuRdata}) !== {expErr, expData}) begin
        testsFailed++;
        $display("[TB] FAIL single_data[%0d] a=%h w=%0d: got err=%0d data=%h expected err=%0d data=%h",
                 i, a, tWide[i], tPort[i] ? datRerr : ifuRerr, tPort[i] ? datRdata : ifuRdata,
                 expErr, expData);
      end
      testsRun++;
      if ((tPort[i] ? {ifuRerr, ifuRdata} : {datRerr, datRdata}) !== 17'h0) begin
        testsFailed++;
        $display("[TB] FAIL single_idle_port[%0d]: got %h expected 0", i,
                 tPort[i] ? {ifuRerr, ifuRdata} : {datRerr, datRdata});
      end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] tAddr[$];
    bit          tWide[$];
    tAddr = '{16'hFFFF, 16'hFFFF, 16'hF800, 16'hF7FF, 16'h0000};
    tWide = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    foreach (tAddr[i]) begin
      logic [15:0] a;
      a = tAddr[i];
      @(posedge clk); #1;
      wIfuReq = 1'b1; wIfuAddr = a; wIfuWide = tWide[i];
      @(negedge clk);
      testsRun++;
      if ({wRomAddrEven, wRomAddrOdd} !== {refEven(a), refOdd(a)}) begin
        testsFailed++;
        $display("[TB] FAIL wrap_addr[%0d] a=%h: got %h/%h expected %h/%h", i, a,
                 wRomAddrEven, wRomAddrOdd, refEven(a), refOdd(a));
      end
      @(posedge clk); #1;
      wIfuReq = 1'b0;
      @(negedge clk);
      testsRun++;
      if ({wIfuRvalid, wIfuRerr, wIfuRdata} !==
          {1'b1, refErr(a, tWide[i], WRAP_BASE), refData(a, tWide[i], WRAP_BASE)}) begin
        testsFailed++;
        $display("[TB] FAIL wrap_rsp[%0d] a=%h w=%0d: got v=%0d err=%0d data=%h expected v=1 err=%0d data=%h",
                 i, a, tWide[i], wIfuRvalid, wIfuRerr, wIfuRdata,
                 refErr(a, tWide[i], WRAP_BASE), refData(a, tWide[i], WRAP_BASE));
      end
    end
  endtask

  task automatic test_tie();
    bit          prevV;
    bit          prevP;
    logic [15:0] prevD;
    logic        prevE;
    int          ifuCount;
    int          datCount;
    prevV = 1'b0; prevP = 1'b0; prevD = '0; prevE = 1'b0;
    ifuCount = 0; datCount = 0;
    pulseReset();
    ifuReq = 1'b1; ifuAddr = randAddr(); ifuWide = 1'($urandom_range(0, 1));
    datReq = 1'b1; datAddr = randAddr(); datWide = 1'($urandom_range(0, 1));
    for (int cyc = 0; cyc <= 4; cyc++) begin
      bit          win;
      logic [15:0] wa;
      @(negedge clk);
      testsRun++;
      if ({ifuRvalid, datRvalid} !== (prevV ? (prevP ? 2'b01 : 2'b10) : 2'b00)) begin
        testsFailed++;
        $display("[TB] FAIL tie_rvalid[%0d]: got %b expected %b", cyc, {ifuRvalid, datRvalid},
                 prevV ? (prevP ? 2'b01 : 2'b10) : 2'b00);
      end
      testsRun++;
      if ({ifuRerr, ifuRdata, datRerr, datRdata} !==
          {(prevV && !prevP) ? {prevE, prevD} : 17'h0, (prevV && prevP) ? {prevE, prevD} : 17'h0}) begin
        testsFailed++;
        $display("[TB] FAIL tie_rsp[%0d]: got ifu %0d/%h dat %0d/%h expected port %0d err=%0d data=%h",
                 cyc, ifuRerr, ifuRdata, datRerr, datRdata, prevP, prevE, prevD);
      end
      if (cyc == 4) break;
      win = tieWinner();
      wa  = win ? datAddr : ifuAddr;
      testsRun++;
      if ({ifuGnt, datGnt} !== (win ? 2'b01 : 2'b10)) begin
        testsFailed++;
        $display("[TB] FAIL tie_gnt[%0d]: got %b expected %b", cyc, {ifuGnt, datGnt}, win ? 2'b01 : 2'b10);
      end
      testsRun++;
      if ({romAddrEven, romAddrOdd} !== {refEven(wa), refOdd(wa)}) begin
        testsFailed++;
        $display("[TB] FAIL tie_addr[%0d]: got %h/%h expected %h/%h", cyc,
                 romAddrEven, romAddrOdd, refEven(wa), refOdd(wa));
      end
      prevV = 1'b1; prevP = win;
      prevD = refData(wa, win ? datWide : ifuWide, BASE);
      prevE = refErr(wa, win ? datWide : ifuWide, BASE);
      noteGrant(win);
      if (win) datCount++; else ifuCount++;
      @(posedge clk); #1;
      if (win) begin
        datAddr = randAddr(); datWide = 1'($urandom_range(0, 1));
      end else begin
        ifuAddr = randAddr(); ifuWide = 1'($urandom_range(0, 1));
      end
      if (cyc == 3) begin
        ifuReq = 1'b0; datReq = 1'b0;
      end
    end
    testsRun++;
`ifdef ROM_ARB_FAIR_EN
    if (ifuCount != 2 || datCount != 2) begin
`else
    if (ifuCount != 0 || datCount != 4) begin
`endif
      testsFailed++;
      $display("[TB] FAIL tie_counts: got ifu=%0d dat=%0d", ifuCount, datCount);
    end
  endtask

  task automatic test_back_to_back();
    bit          ifuPend, datPend;
    bit          prevV, prevP;
    logic [15:0] prevD;
    logic        prevE;
    ifuPend = 1'b0; datPend = 1'b0;
    prevV = 1'b0; prevP = 1'b0; prevD = '0; prevE = 1'b0;
    for (int cyc = 0; cyc <= 300; cyc++) begin
      bit          hasWin;
      bit          win;
      logic [15:0] wa;
      @(posedge clk); #1;
      if (ifuPend && $urandom_range(0, 9) == 0) ifuPend = 1'b0;
      if (datPend && $urandom_range(0, 9) == 0) datPend = 1'b0;
      if (cyc < 300) begin
        if (!ifuPend && $urandom_range(0, 1) == 1) begin
          ifuPend = 1'b1; ifuAddr = randAddr(); ifuWide = 1'($urandom_range(0, 1));
        end
        if (!datPend && $urandom_range(0, 1) == 1) begin
          datPend = 1'b1; datAddr = randAddr(); datWide = 1'($urandom_range(0, 1));
        end
      end else begin
        ifuPend = 1'b0; datPend = 1'b0;
      end
      ifuReq = ifuPend; datReq = datPend;
      @(negedge clk);
      testsRun++;
      if ({ifuRvalid, datRvalid} !== (prevV ? (prevP ? 2'b01 : 2'b10) : 2'b00)) begin
        testsFailed++;
        $display("[TB] FAIL b2b_rvalid[%0d]: got %b expected %b", cyc, {ifuRvalid, datRvalid},
                 prevV ? (prevP ? 2'b01 : 2'b10) : 2'b00);
      end
      testsRun++;
      if ({ifuRerr, ifuRdata, datRerr, datRdata} !==
          {(prevV && !prevP) ? {prevE, prevD} : 17'h0, (prevV && prevP) ? {prevE, prevD} : 17'h0}) begin
        testsFailed++;
        $display("[TB] FAIL b2b_rsp[%0d]: got ifu %0d/%h dat %0d/%h expected port %0d err=%0d data=%h",
                 cyc, ifuRerr, ifuRdata, datRerr, datRdata, prevP, prevE, prevD);
      end
      hasWin = ifuPend || datPend;
      if (ifuPend && datPend) win = tieWinner();
      else                    win = datPend;
      testsRun++;
      if ({ifuGnt, datGnt} !== (hasWin ? (win ? 2'b01 : 2'b10) : 2'b00)) begin
        testsFailed++;
        $display("[TB] FAIL b2b_gnt[%0d]: got %b expected %b", cyc, {ifuGnt, datGnt},
                 hasWin ? (win ? 2'b01 : 2'b10) : 2'b00);
      end
      prevV = hasWin;
      if (hasWin) begin
        wa = win ? datAddr : ifuAddr;
        testsRun++;
        if ({romAddrEven, romAddrOdd} !== {refEven(wa), refOdd(wa)}) begin
          testsFailed++;
          $display("[TB] FAIL b2b_addr[%0d] a=%h: got %h/%h expected %h/%h", cyc, wa,
                   romAddrEven, romAddrOdd, refEven(wa), refOdd(wa));
        end
        prevP = win;
        prevD = refData(wa, win ? datWide : ifuWide, BASE);
        prevE = refErr(wa, win ? datWide : ifuWide, BASE);
        noteGrant(win);
        if (win) datPend = 1'b0; else ifuPend = 1'b0;
      end
    end
    @(posedge clk); #1;
    ifuReq = 1'b0; datReq = 1'b0;
  endtask

  task automatic test_reset_pending();
    @(posedge clk); #1;
    ifuReq = 1'b1; ifuAddr = 16'h4020; ifuWide = 1'b1;
    @(negedge clk);
    testsRun++;
    if (ifuGnt !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL rstpend_gnt: got %b expected 1", ifuGnt);
    end
    @(posedge clk); #1;
    ifuReq = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    testsRun++;
    if ({ifuGnt, datGnt, ifuRvalid, datRvalid, ifuRerr, datRerr, ifuRdata, datRdata} !== 38'h0) begin
      testsFailed++;
      $display("[TB] FAIL rstpend_during: got %h expected 0",
               {ifuGnt, datGnt, ifuRvalid, datRvalid, ifuRerr, datRerr, ifuRdata, datRdata});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      testsRun++;
      if ({ifuRvalid, datRvalid} !== 2'b00) begin
        testsFailed++;
        $display("[TB] FAIL rstpend_after[%0d]: got %b expected 00", k, {ifuRvalid, datRvalid});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_tie();
    test_back_to_back();
    test_reset_pending();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Shares the dual-bank (even/odd byte) synchronous ROM between two requesters: the instruction-fetch unit (ifu) and the data port (dat). Each cycle it grants at most one request and drives both bank addresses, so that one 16-bit word, aligned or unaligned, or one byte is read per grant. It returns the steered little-endian result one cycle later, with an out-of-range error flag. It sits between the core's memory interface and the ROM instance.

## Interface
- SIZE, 2048: ROM size in bytes (power of two, ≤ 32768).
- ROMBASE, 16'h4000: byte address of ROM offset 0 (even).
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ifu_req  in  1  ifu request; held with its attributes until ifu_gnt.
- ifu_addr  in  16  ifu byte address.
- ifu_wide  in  1  1 = 16-bit read at addr, addr+1; 0 = byte read.
- ifu_gnt  out  1  combinational grant, same cycle as ifu_req.
- ifu_rvalid  out  1  registered; response for ifu is valid.
- ifu_rdata  out  16  response data; byte reads are zero-extended.
- ifu_rerr  out  1  response address out of range.
- dat_req, dat_addr, dat_wide, dat_gnt, dat_rvalid, dat_rdata, dat_rerr: same as the ifu ports, for the data port.
- rom_addr_even  out  15  even-bank word address (byte address bits [15:1]).
- rom_addr_odd  out  15  odd-bank word address.
- rom_data_even  in  8  even-bank data, valid one cycle after address.
- rom_data_odd  in  8  odd-bank data, valid one cycle after address.

## Operation
- Arbitration: if only one port requests, that port is granted. If both request, the winner follows the Configuration section. The loser keeps ifu_req/dat_req asserted and is granted in a later cycle.
- Bank addressing for the granted byte address a:
  - a even: rom_addr_even = a[15:1]; rom_addr_odd = a[15:1].
  - a odd: rom_addr_odd = a[15:1]; rom_addr_even = (a+1)[15:1], computed as 16-bit addition with wrap at 16'hFFFF.
  - With no grant, the addresses hold their last value (don't-care, but stable).
- Response tag registered at grant: port, a[0], wide, err.
- Steering (combinational from tag and rom_data):
  - a[0]=0: rdata = {wide ? even_hi... } i.e. low byte = rom_data_even, high byte = wide ? rom_data_odd : 8'h00.
  - a[0]=1: low byte = rom_data_odd, high byte = wide ? rom_data_even : 8'h00.
- Range check:
  - offset o = a − ROMBASE, mod 2^16.
  - Byte read in range iff o < SIZE. Wide read additionally requires (o+1) mod 2^16 < SIZE.
  - When err = 1, rdata = 16'h0000 and rerr = 1; rvalid is still asserted.
- rdata and rerr of a port are don't-care while its rvalid = 0; hold them at 0 for determinism.
- No response backpressure: a requester must accept the response in its rvalid cycle.

## Timing
- Grant is in cycle N (combinational from req). Response is on rvalid in cycle N+1, exactly one cycle, on the granted port only.
- Back-to-back grants: one per cycle, at full throughput; responses pipeline 1:1.
- Reset values: ifu_rvalid = dat_rvalid = 0, rdata = 0, rerr = 0, last-granted pointer = dat (so ifu wins the first tie when fair).
- gnt outputs are 0 while reset is high.
- Reset asserted while a response is pending drops that response; no rvalid follows after reset releases.
- A requester that deasserts req before its grant cancels the request; no error results.

## Configuration
- ROM_ARB_FAIR_EN defined: round-robin arbitration. On a tie, the port not granted most recently wins. The pointer updates on every grant.
- ROM_ARB_FAIR_EN undefined: fixed priority, dat always wins ties, and ifu may starve. The pointer register is omitted.

## Structure
- Package rom_arb_pkg:
  - port_e enum {PORT_IFU, PORT_DAT};
  - rsp_tag_t packed struct {port_e port; logic odd; logic wide; logic err};
  - in-range function taking addr, wide, ROMBASE and SIZE.
- Sub-module rom_arb_steer: combinational byte-lane steering and zero-masking from rsp_tag_t and the two bank bytes.

## Test plan
ROM image: byte at offset i = i[7:0]; ROMBASE 16'h4000; SIZE 2048.
- ifu wide read at 16'h4010: rom_addr_even = rom_addr_odd = 15'h2008; next cycle ifu_rvalid = 1, ifu_rdata = 16'h1110, ifu_rerr = 0.
- dat wide read at 16'h4011: rom_addr_odd = 15'h2008, rom_addr_even = 15'h2009; dat_rdata = 16'h1211.
- dat byte read at 16'h47FF gives 16'h00FF with rerr = 0. Wide read at 16'h47FF gives rdata 0 with rerr = 1. Wide read at 16'h3FFF gives rerr = 1.
- Both ports request continuously for 4 cycles:
  - fair build: grants alternate ifu, dat, ifu, dat;
  - unfair build: dat is granted 4 times and ifu 0 times.
  - Both builds: each response appears on the correct port one cycle after its grant.
- Wrap check: wide read at 16'hFFFF with ROMBASE 16'hF800 gives rom_addr_even = 15'h0000 and rerr = 1, since offset 0x0800 is not below SIZE.
- reset pulse in the cycle after a grant: no rvalid in the following cycle; all outputs are 0 during reset.
